pc_sequencer: RTL and testbench

//  Program-counter sequencer for the fetch stage. Holds the D-bit PC and runs a

---
 rtl/pc_sequencer_pkg.sv | 9 +
 rtl/pc_sequencer_next_calc.sv | 33 +++
 rtl/pc_sequencer.sv | 88 ++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  localparam int D_DEF  = 12;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Next-PC priority mux: stall/halt hold, then jump, taken branch, sequential.
// Purely combinational; all arithmetic wraps modulo 2^D.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int D = D_DEF
) (
  input  logic [D-1:0] pc,
  input  logic         stall,
  input  logic         halt,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         branch_taken,
  input  logic [D-1:0] target,
  input  logic [D-1:0] jump_addr,
  output logic [D-1:0] next_pc
);

  localparam logic [D-1:0] PC_ONE = D'(1);

  always_comb begin
    next_pc = pc + PC_ONE;
    if (stall || halt) begin
      next_pc = pc;
    end else if (jump_en) begin
      next_pc = jump_addr;
    end else if (branch_en && branch_taken) begin
      // target is already D-bit two's complement, so a plain D-bit add is the signed add
      next_pc = pc + target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer with IDLE/RUN/DONE program FSM and saturating retire count.
// Latency: new PC one clk after the deciding inputs; stall holds PC and count in RUN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int             D          = D_DEF,
  parameter int             CW         = CW_DEF,
  parameter logic [D-1:0]   START_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  input  logic          jump_en,
  input  logic [D-1:0]  jump_addr,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  seq_state_t    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  next_pc;

  pc_next_calc #(.D(D)) u_next_calc (
    .pc           (pc_q),
    .stall        (stall),
    .halt         (halt),
    .jump_en      (jump_en),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .target       (target),
    .jump_addr    (jump_addr),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: no mid-run restart
        if (!stall) begin
          pc_d  = next_pc;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
          if (halt) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prog_ctr    = pc_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; count width shrunk to 5 so saturation is reachable.
module tb_pc_sequencer;

  localparam int D  = 12;
  localparam int CW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic          branch_taken;
  logic [D-1:0]  target;
  logic          jump_en;
  logic [D-1:0]  jump_addr;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [CW-1:0] instr_count;

  int checks_total;
  int checks_passed;

  pc_sequencer #(.D(D), .CW(CW), .START_ADDR('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .halt         (halt),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .target       (target),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Advance one edge and settle 1ns after it; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_en = 1'b0; branch_taken = 1'b0; target = '0;
    jump_en = 1'b0; jump_addr = '0;

    #23;
    check("rst_pc",      32'(prog_ctr),    32'h0);
    check("rst_running", 32'(running),     32'h0);
    check("rst_done",    32'(done),        32'h0);
    check("rst_count",   32'(instr_count), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 1: start then plain sequential stepping
    start = 1'b1; step(); start = 1'b0;
    check("start_pc",      32'(prog_ctr),    32'h0);
    check("start_running", 32'(running),     32'h1);
    check("start_count",   32'(instr_count), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("seq_pc_%0d", i), 32'(prog_ctr), 32'(i));
    end
    check("seq_count5", 32'(instr_count), 32'd5);
    for (int i = 0; i < 5; i++) step();
    check("seq_pc10", 32'(prog_ctr), 32'd10);

    // Test 2: taken backward branch, then not-taken, then taken without enable
    branch_en = 1'b1; branch_taken = 1'b1; target = 12'hFFB;
    step();
    check("br_back_pc", 32'(prog_ctr), 32'd5);
    branch_en = 1'b0; branch_taken = 1'b0;
    jump_en = 1'b1; jump_addr = 12'd10;
    step();
    check("jmp10_pc", 32'(prog_ctr), 32'd10);
    jump_en = 1'b0;
    branch_en = 1'b1; branch_taken = 1'b0; target = 12'hFFB;
    step();
    check("br_nt_pc", 32'(prog_ctr), 32'd11);
    branch_en = 1'b0; branch_taken = 1'b1;
    step();
    check("br_noen_pc", 32'(prog_ctr), 32'd12);
    check("br_count14", 32'(instr_count), 32'd14);

    // Test 3: wrap below zero and past the top, then a self-loop branch
    branch_taken = 1'b0; jump_en = 1'b1; jump_addr = 12'h000;
    step();
    check("jmp0_pc", 32'(prog_ctr), 32'h0);
    jump_en = 1'b0; branch_en = 1'b1; branch_taken = 1'b1; target = 12'hFFF;
    step();
    check("wrap_neg_pc", 32'(prog_ctr), 32'hFFF);
    branch_en = 1'b0; branch_taken = 1'b0;
    step();
    check("wrap_pos_pc", 32'(prog_ctr), 32'h0);
    branch_en = 1'b1; branch_taken = 1'b1; target = 12'h000;
    step();
    check("selfloop_pc",    32'(prog_ctr),    32'h0);
    check("selfloop_count", 32'(instr_count), 32'd18);

    // Test 4: stall dominates halt and jump
    branch_en = 1'b0; branch_taken = 1'b0;
    jump_en = 1'b1; jump_addr = 12'd7;
    step();
    stall = 1'b1; halt = 1'b1; jump_addr = 12'h100;
    step();
    check("stall_pc",      32'(prog_ctr),    32'd7);
    check("stall_count",   32'(instr_count), 32'd19);
    check("stall_running", 32'(running),     32'h1);
    stall = 1'b0; halt = 1'b0;
    step();
    jump_en = 1'b0;
    check("jmp100_pc",    32'(prog_ctr),    32'h100);
    check("jmp100_count", 32'(instr_count), 32'd20);

    // Test 6: asynchronous reset between edges takes effect before the next edge
    #3;
    reset = 1'b1;
    #1;
    check("arst_pc",      32'(prog_ctr),    32'h0);
    check("arst_running", 32'(running),     32'h0);
    check("arst_done",    32'(done),        32'h0);
    check("arst_count",   32'(instr_count), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 5: 20 retirements (with an ignored start), halt, freeze, restart
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      start = (i == 7);
      step();
    end
    start = 1'b0;
    check("run20_pc",    32'(prog_ctr),    32'd20);
    check("run20_count", 32'(instr_count), 32'd20);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_pc",      32'(prog_ctr),    32'd20);
    check("halt_count",   32'(instr_count), 32'd21);
    check("halt_done",    32'(done),        32'h1);
    check("halt_running", 32'(running),     32'h0);
    jump_en = 1'b1; jump_addr = 12'd55;
    step();
    jump_en = 1'b0;
    check("frozen_pc",    32'(prog_ctr),    32'd20);
    check("frozen_count", 32'(instr_count), 32'd21);
    check("frozen_done",  32'(done),        32'h1);
    start = 1'b1; step(); start = 1'b0;
    check("restart_pc",      32'(prog_ctr),    32'h0);
    check("restart_count",   32'(instr_count), 32'h0);
    check("restart_running", 32'(running),     32'h1);
    check("restart_done",    32'(done),        32'h0);

    // Count saturates at 2^CW-1 = 31 while the PC keeps advancing
    for (int i = 0; i < 35; i++) step();
    check("sat_count", 32'(instr_count), 32'd31);
    check("sat_pc",    32'(prog_ctr),    32'd35);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
